pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MTVEC_ALIGN_CHK, default 1; 1 = trap/return targets are also checked for misalignment.
REQ-003 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- pc_source  in  3  next-PC select: 0 = PC+4, 1 = jalr, 2 = branch, 3 = jal, 4 = mtvec, 5 = mepc, 6–7 = hold.
- pc_write  in  1  request to update PC this cycle.
- jal_addr, branch_addr, jalr_addr  in  32 each  target addresses from the branch address generator.
- mtvec, mepc  in  32 each  trap entry and return addresses.
- imem_ack  in  1  instruction memory has returned the word at imem_addr.
- imem_req  out  1  one-cycle fetch strobe.
- imem_addr  out  32  equals PC.
- pc  out  32  current PC.
- pc_plus4  out  32  combinational PC+4, used as link value.
- ir_valid  out  1  fetched instruction is valid; PC may be updated.
- misalign_err  out  1  one-cycle pulse on a rejected misaligned target.
- mtval  out  32  last rejected target.
- redirect_cnt  out  32  count of non-sequential PC updates.

Function
REQ-004 SHALL implement FSM states FETCH, WAIT, HOLD.
REQ-005 FETCH SHALL assert imem_req for exactly one cycle, then go to WAIT unconditionally.
REQ-006 WAIT SHALL hold imem_req low and go to HOLD on the cycle after imem_ack=1; otherwise it stays in WAIT with no timeout.
REQ-007 HOLD SHALL assert ir_valid=1; ir_valid SHALL be 0 in every other state.
REQ-008 In HOLD with pc_write=1 and a legal target, PC SHALL load the selected target at the clock edge and the FSM SHALL go to FETCH.
REQ-009 pc_source 6 or 7 with pc_write=1 SHALL leave PC unchanged and SHALL re-enter FETCH, which re-fetches the same address.
REQ-010 A target is illegal when bits [1:0] are not 00; pc_source 4/5 are checked only when MTVEC_ALIGN_CHK=1.
- On an illegal target: PC is unchanged, the FSM stays in HOLD, misalign_err=1 for one cycle, and mtval captures the target.
REQ-011 pc_write SHALL be ignored in FETCH and WAIT, with no PC change, no error and no count.
REQ-012 imem_ack SHALL be ignored in FETCH and HOLD.
REQ-013 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000 with no flag.
REQ-014 imem_addr SHALL equal pc at all times; pc_plus4 SHALL equal pc+4 combinationally.
REQ-015 PC SHALL change only on a legal HOLD update, so the update latency is exactly 1 clock after pc_write is sampled.
REQ-016 Minimum fetch-to-HOLD latency SHALL be 3 cycles: FETCH, WAIT with ack, then HOLD.

Reset
REQ-017 When RST=1 is sampled, the block SHALL set pc=RESET_VEC, state=FETCH, misalign_err=0, mtval=0 and redirect_cnt=0.
REQ-018 RST SHALL take priority over pc_write and imem_ack in the same cycle.
REQ-019 Reset in WAIT SHALL abandon the outstanding fetch; an ack arriving during reset SHALL be ignored.
REQ-020 The first imem_req SHALL occur in the first cycle after RST is deasserted.

Configuration
REQ-021 Macro PC_REDIRECT_CNT_EN SHALL control the redirect counter.
- Defined: redirect_cnt increments by 1 on each legal HOLD update with pc_source in 1–5, wraps at 2^32, and is not incremented on errors or holds.
- Undefined: redirect_cnt is tied to 0 and no counter register is synthesized.

Verification
REQ-022 Reset → deassert, ack on the 2nd cycle: imem_req pulses once with imem_addr=0 → ir_valid=1; pc_write with source 0 → pc=4, next imem_req shows addr 4.
REQ-023 HOLD, pc=0x100, source=3, jal_addr=0x200 → pc=0x200 after one edge, FSM in FETCH; with the macro defined, redirect_cnt=1.
REQ-024 HOLD, source=1, jalr_addr=0x202 → pc stays 0x100, misalign_err pulses one cycle, mtval=0x202, ir_valid stays 1, counter unchanged.
REQ-025 pc=0xFFFF_FFFC, source=0 → pc=0x0000_0000, pc_plus4 transitions from 0x0 to 0x4.
REQ-026 In WAIT, assert RST together with imem_ack → pc=RESET_VEC, then FETCH; pc_write held high during FETCH/WAIT causes no PC change.

Source files
------------

// File: rtl/pc_unit_if.sv
// Bus between the PC unit and its controller, branch address generator and instruction memory.
interface pc_unit_if;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic [31:0] jal_addr;
    logic [31:0] branch_addr;
    logic [31:0] jalr_addr;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        misalign_err;
    logic [31:0] mtval;
    logic [31:0] redirect_cnt;

    modport master (
        output pc_source, pc_write, jal_addr, branch_addr, jalr_addr, mtvec, mepc, imem_ack,
        input  imem_req, imem_addr, pc, pc_plus4, ir_valid, misalign_err, mtval, redirect_cnt
    );

    modport slave (
        input  pc_source, pc_write, jal_addr, branch_addr, jalr_addr, mtvec, mepc, imem_ack,
        output imem_req, imem_addr, pc, pc_plus4, ir_valid, misalign_err, mtval, redirect_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with fetch handshake FSM (FETCH/WAIT/HOLD) and misaligned-target rejection.
// Optional redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_unit #(
    parameter logic [31:0] RESET_VEC       = 32'h0000_0000,
    parameter bit          MTVEC_ALIGN_CHK = 1'b1
) (
    input logic CLK,
    input logic RST,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] mtval_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        illegal;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        case (bus.pc_source)
            3'd0:    target = pc_plus4;
            3'd1:    target = bus.jalr_addr;
            3'd2:    target = bus.branch_addr;
            3'd3:    target = bus.jal_addr;
            3'd4:    target = bus.mtvec;
            3'd5:    target = bus.mepc;
            default: target = pc_q;
        endcase
        // Hold sources never fault; trap/return targets only when the check is enabled.
        illegal = (target[1:0] != 2'b00) && (bus.pc_source <= 3'd5)
                  && ((bus.pc_source < 3'd4) || MTVEC_ALIGN_CHK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc_q    <= RESET_VEC;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mtval_q <= 32'h0;
        end else begin
            err_q <= 1'b0;
            case (state)
                FETCH: begin
                    state <= WAIT;
                    req_q <= 1'b0;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.pc_write) begin
                        if (illegal) begin
                            err_q   <= 1'b1;
                            mtval_q <= target;
                        end else begin
                            pc_q    <= target;
                            state   <= FETCH;
                            req_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] cnt_q;
    logic        redirect;

    assign redirect = (bus.pc_source >= 3'd1) && (bus.pc_source <= 3'd5);

    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= 32'h0;
        else if (state == HOLD && bus.pc_write && !illegal && redirect)
            cnt_q <= cnt_q + 32'd1;
    end

    assign bus.redirect_cnt = cnt_q;
`else
    assign bus.redirect_cnt = 32'h0;
`endif

    assign bus.pc           = pc_q;
    assign bus.imem_addr    = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.imem_req     = req_q;
    assign bus.ir_valid     = valid_q;
    assign bus.misalign_err = err_q;
    assign bus.mtval        = mtval_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: fixed vector table, hand-written corner sequences and a random run.
module tb_pc_unit;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam bit          CHK = 1'b1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    pc_unit_if bus();

    pc_unit #(.RESET_VEC(RV), .MTVEC_ALIGN_CHK(CHK)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        bit          exp_err;
        bit          inc;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef PC_REDIRECT_CNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Selected field gets the target; every other field gets a distinct aligned decoy.
    task automatic set_tgt(input logic [2:0] src, input logic [31:0] tgt);
        bus.pc_source   = src;
        bus.jalr_addr   = (src == 3'd1) ? tgt : 32'h1000_0010;
        bus.branch_addr = (src == 3'd2) ? tgt : 32'h1000_0020;
        bus.jal_addr    = (src == 3'd3) ? tgt : 32'h1000_0030;
        bus.mtvec       = (src == 3'd4) ? tgt : 32'h1000_0040;
        bus.mepc        = (src == 3'd5) ? tgt : 32'h1000_0050;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.pc_write = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        step();
        RST = 1'b0;
        m_pc  = RV;
        m_cnt = 32'h0;
    endtask

    // Entered at a negedge while fetching; leaves at a negedge in the valid/hold phase.
    task automatic fetch_to_hold(input int waits);
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        chk("fetch_ivld", 32'(bus.ir_valid), 32'd0);
        bus.imem_ack  = 1'($urandom_range(0, 1));
        bus.pc_write  = 1'($urandom_range(0, 1));
        bus.pc_source = 3'($urandom);
        step();
        bus.imem_ack = 1'b0;
        chk("wait_req", 32'(bus.imem_req), 32'd0);
        chk("wait_pc", bus.pc, m_pc);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_ivld", 32'(bus.ir_valid), 32'd0);
            chk("wait_pc", bus.pc, m_pc);
        end
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        bus.pc_write = 1'b0;
        chk("hold_ivld", 32'(bus.ir_valid), 32'd1);
        chk("hold_pc", bus.pc, m_pc);
    endtask

    // One pc_write request in the hold phase, checked against the architectural rules.
    task automatic hold_op(input logic [2:0] src, input logic [31:0] tgt, output bit legal);
        logic [31:0] t;
        bit bad_align;
        t = (src == 3'd0) ? m_pc + 32'd4 : tgt;
        bad_align = (src <= 3'd5) && (t[1:0] != 2'b00) && ((src < 3'd4) || CHK);
        set_tgt(src, tgt);
        bus.pc_write = 1'b1;
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        step();
        bus.pc_write = 1'b0;
        if (bad_align) begin
            chk("err_pulse", 32'(bus.misalign_err), 32'd1);
            chk("err_mtval", bus.mtval, t);
            chk("err_ivld", 32'(bus.ir_valid), 32'd1);
            chk("err_pc", bus.pc, m_pc);
            chk("err_cnt", bus.redirect_cnt, exp_cnt());
            step();
            chk("err_clear", 32'(bus.misalign_err), 32'd0);
            chk("err_stay", 32'(bus.ir_valid), 32'd1);
            legal = 1'b0;
        end else begin
            if (src <= 3'd5) m_pc = t;
            if (src >= 3'd1 && src <= 3'd5) m_cnt = m_cnt + 32'd1;
            chk("upd_pc", bus.pc, m_pc);
            chk("upd_req", 32'(bus.imem_req), 32'd1);
            chk("upd_addr", bus.imem_addr, m_pc);
            chk("upd_ivld", 32'(bus.ir_valid), 32'd0);
            chk("upd_err", 32'(bus.misalign_err), 32'd0);
            chk("upd_cnt", bus.redirect_cnt, exp_cnt());
            legal = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int n;
        logic [31:0] r;

        tv[0]  = '{3'd0, 32'h0,         32'h104, 1'b0, 1'b0};
        tv[1]  = '{3'd1, 32'h300,       32'h300, 1'b0, 1'b1};
        tv[2]  = '{3'd2, 32'h400,       32'h400, 1'b0, 1'b1};
        tv[3]  = '{3'd3, 32'h200,       32'h200, 1'b0, 1'b1};
        tv[4]  = '{3'd4, 32'h800,       32'h800, 1'b0, 1'b1};
        tv[5]  = '{3'd5, 32'h900,       32'h900, 1'b0, 1'b1};
        tv[6]  = '{3'd6, 32'h0,         32'h100, 1'b0, 1'b0};
        tv[7]  = '{3'd7, 32'h0,         32'h100, 1'b0, 1'b0};
        tv[8]  = '{3'd1, 32'h202,       32'h100, 1'b1, 1'b0};
        tv[9]  = '{3'd2, 32'h401,       32'h100, 1'b1, 1'b0};
        tv[10] = '{3'd4, 32'h803,       32'h100, 1'b1, 1'b0};
        tv[11] = '{3'd5, 32'h901,       32'h100, 1'b1, 1'b0};

        bus.pc_source = 3'd0;
        set_tgt(3'd0, 32'h0);
        do_reset();

        chk("rst_pc", bus.pc, RV);
        chk("rst_req", 32'(bus.imem_req), 32'd1);
        chk("rst_ivld", 32'(bus.ir_valid), 32'd0);
        chk("rst_err", 32'(bus.misalign_err), 32'd0);
        chk("rst_mtval", bus.mtval, 32'h0);
        chk("rst_cnt", bus.redirect_cnt, 32'h0);

        // Ack on the 2nd cycle, then sequential step to 4.
        fetch_to_hold(0);
        hold_op(3'd0, 32'h0, ok);
        chk("seq_pc4", bus.pc, 32'h4);
        fetch_to_hold(0);

        for (int i = 0; i < 12; i++) begin
            hold_op(3'd3, 32'h100, ok);
            fetch_to_hold(1);
            set_tgt(tv[i].src, tv[i].tgt);
            bus.pc_write = 1'b1;
            step();
            bus.pc_write = 1'b0;
            m_pc  = tv[i].exp_pc;
            m_cnt = m_cnt + 32'(tv[i].inc);
            chk("tv_pc", bus.pc, tv[i].exp_pc);
            chk("tv_err", 32'(bus.misalign_err), 32'(tv[i].exp_err));
            chk("tv_ivld", 32'(bus.ir_valid), 32'(tv[i].exp_err));
            chk("tv_cnt", bus.redirect_cnt, exp_cnt());
            if (tv[i].exp_err) begin
                chk("tv_mtval", bus.mtval, tv[i].tgt);
                step();
                chk("tv_errclr", 32'(bus.misalign_err), 32'd0);
            end else begin
                fetch_to_hold(0);
            end
        end

        // Wrap from the top of the address space.
        hold_op(3'd3, 32'hFFFF_FFFC, ok);
        fetch_to_hold(2);
        chk("wrap_p4a", bus.pc_plus4, 32'h0);
        hold_op(3'd0, 32'h0, ok);
        chk("wrap_pc", bus.pc, 32'h0);
        fetch_to_hold(0);
        chk("wrap_p4b", bus.pc_plus4, 32'h4);

        // Reset with ack while waiting, then pc_write held through fetch/wait.
        hold_op(3'd3, 32'h40, ok);
        step();
        RST = 1'b1;
        bus.imem_ack = 1'b1;
        set_tgt(3'd3, 32'h500);
        bus.pc_write = 1'b1;
        step();
        RST = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc  = RV;
        m_cnt = 32'h0;
        chk("wrst_pc", bus.pc, RV);
        chk("wrst_req", 32'(bus.imem_req), 32'd1);
        chk("wrst_ivld", 32'(bus.ir_valid), 32'd0);
        chk("wrst_mtval", bus.mtval, 32'h0);
        chk("wrst_cnt", bus.redirect_cnt, 32'h0);
        step();
        chk("pw_fetch_pc", bus.pc, RV);
        step();
        chk("pw_wait_pc", bus.pc, RV);
        chk("pw_wait_ivld", 32'(bus.ir_valid), 32'd0);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        bus.pc_write = 1'b0;
        chk("pw_hold_pc", bus.pc, RV);
        chk("pw_hold_ivld", 32'(bus.ir_valid), 32'd1);

        // Reset wins over a legal update in the hold phase.
        RST = 1'b1;
        set_tgt(3'd3, 32'h500);
        bus.pc_write = 1'b1;
        step();
        RST = 1'b0;
        bus.pc_write = 1'b0;
        chk("hrst_pc", bus.pc, RV);
        chk("hrst_req", 32'(bus.imem_req), 32'd1);
        m_pc  = RV;
        m_cnt = 32'h0;

        for (int it = 0; it < 250; it++) begin
            fetch_to_hold($urandom_range(0, 3));
            n = 0;
            ok = 1'b0;
            while (!ok && n < 6) begin
                if ($urandom_range(0, 3) == 0) begin
                    step();
                    chk("idle_pc", bus.pc, m_pc);
                    chk("idle_ivld", 32'(bus.ir_valid), 32'd1);
                end
                r = $urandom;
                if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
                hold_op(3'($urandom_range(0, 7)), r, ok);
                n++;
            end
            if (!ok) hold_op(3'd3, {$urandom} & 32'hFFFF_FFFC, ok);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
